// File: rtl/decodificador_alarme_if.sv
// Indicator bus between the alarm controller side and the status decoder.
//   led, sirene : indicator lines driven by the alarm controller
//   estado      : decoded controller state (00 standby, 01 alert, 10 triggered, 11 unknown)
//   valido      : estado holds a known state
//   mudou       : one-cycle pulse on each estado change
//   erro        : one-cycle pulse on a blink-encoding violation
interface decodificador_alarme_if;
    logic       led;
    logic       sirene;
    logic [1:0] estado;
    logic       valido;
    logic       mudou;
    logic       erro;

    modport master (output led, output sirene,
                    input  estado, input valido, input mudou, input erro);
    modport slave  (input  led, input sirene,
                    output estado, output valido, output mudou, output erro);
endinterface

// File: rtl/decodificador_alarme.sv
// Status decoder for the alarm panel indicators. Measures toggle intervals
// on led/sirene and recovers the alarm controller state.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : decodificador_alarme_if.slave (led/sirene in; estado/valido/mudou/erro out)
//
// state        | meaning
// ST_STANDBY   | quiet line: led steady high, sirene low
// ST_ALERTA    | led blinking with ALERTA_HALF half-period
// ST_DISPARO   | led blinking with DISPARO_HALF half-period, siren active
// ST_INDET     | after reset or a stuck-level timeout
module decodificador_alarme #(
    parameter int ALERTA_HALF  = 4,
    parameter int DISPARO_HALF = 2,
    parameter int SIRENE_HALF  = 6,
    parameter int TOL          = 0,
    parameter int TIMEOUT      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    decodificador_alarme_if.slave bus
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_STANDBY = 2'b00,
        ST_ALERTA  = 2'b01,
        ST_DISPARO = 2'b10,
        ST_INDET   = 2'b11
    } estado_t;

    typedef enum logic [1:0] {
        CAND_NONE    = 2'b00,
        CAND_ALERTA  = 2'b01,
        CAND_DISPARO = 2'b10
    } cand_t;

    logic          led_s, sir_s, samp_v;
    logic          led_p, sir_p, prev_v;
    logic [CW-1:0] led_q, sir_q, led_q_nx, sir_q_nx;
    logic          led_meas, sir_meas, led_meas_nx, sir_meas_nx;
    logic          led_edge, sir_edge;
    cand_t         cand, cand_nx, cls;
    estado_t       st, st_nx, est_r;
    logic          err_b, err_nx;
    logic          val_r, mud_r, err_r;

    // Counters hold quiet cycles since the last edge, so the interval is q + 1.
    function automatic logic in_band(input logic [CW-1:0] q, input int center);
        int iv;
        iv = int'(q) + 1;
        return (iv >= center - TOL) && (iv <= center + TOL);
    endfunction

    // Input sample stage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led_s  <= 1'b0;
            sir_s  <= 1'b0;
            samp_v <= 1'b0;
        end else begin
            led_s  <= bus.led;
            sir_s  <= bus.sirene;
            samp_v <= 1'b1;
        end
    end

    // Measurement / decode state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led_p    <= 1'b0;
            sir_p    <= 1'b0;
            prev_v   <= 1'b0;
            led_q    <= '0;
            sir_q    <= '0;
            led_meas <= 1'b0;
            sir_meas <= 1'b0;
            cand     <= CAND_NONE;
            st       <= ST_INDET;
            err_b    <= 1'b0;
        end else begin
            if (samp_v) begin
                led_p  <= led_s;
                sir_p  <= sir_s;
                prev_v <= 1'b1;
            end
            led_q    <= led_q_nx;
            sir_q    <= sir_q_nx;
            led_meas <= led_meas_nx;
            sir_meas <= sir_meas_nx;
            cand     <= cand_nx;
            st       <= st_nx;
            err_b    <= err_nx;
        end
    end

    // The first valid sample after reset only becomes the edge reference.
    assign led_edge = prev_v && (led_s != led_p);
    assign sir_edge = prev_v && (sir_s != sir_p);

    always_comb begin
        led_q_nx    = led_q;
        sir_q_nx    = sir_q;
        led_meas_nx = led_meas;
        sir_meas_nx = sir_meas;
        cand_nx     = cand;
        st_nx       = st;
        err_nx      = 1'b0;
        cls         = CAND_NONE;

        if (samp_v) begin
            if (led_edge) begin
                led_q_nx    = '0;
                led_meas_nx = 1'b1;
                if (led_meas) begin
                    if (in_band(led_q, DISPARO_HALF))
                        cls = CAND_DISPARO;
                    else if (in_band(led_q, ALERTA_HALF))
                        cls = CAND_ALERTA;

                    if (cls == CAND_NONE) begin
                        err_nx  = 1'b1;
                        cand_nx = CAND_NONE;
                    end else if (cls == cand) begin
                        st_nx = (cls == CAND_DISPARO) ? ST_DISPARO : ST_ALERTA;
                    end else begin
                        cand_nx = cls;
                    end
                end
            end else if (led_q != CNT_MAX) begin
                led_q_nx = led_q + CW'(1);
                // Fires once, on the quiet cycle that brings the counter to TIMEOUT.
                if (led_q == CNT_LAST) begin
                    led_meas_nx = 1'b0;
                    cand_nx     = CAND_NONE;
                    st_nx       = (led_s && !sir_s) ? ST_STANDBY : ST_INDET;
                end
            end

            // Siren checks use the state held before this cycle's led update.
            if (sir_edge) begin
                sir_q_nx    = '0;
                sir_meas_nx = 1'b1;
                if (st == ST_STANDBY || st == ST_ALERTA)
                    err_nx = 1'b1;
                if (sir_meas && !in_band(sir_q, SIRENE_HALF))
                    err_nx = 1'b1;
            end else if (sir_q != CNT_MAX) begin
                sir_q_nx = sir_q + CW'(1);
            end
        end
    end

    // Output register stage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            est_r <= ST_INDET;
            val_r <= 1'b0;
            mud_r <= 1'b0;
            err_r <= 1'b0;
        end else begin
            est_r <= st;
            val_r <= (st != ST_INDET);
            mud_r <= (st != est_r);
            err_r <= err_b;
        end
    end

    assign bus.estado = est_r;
    assign bus.valido = val_r;
    assign bus.mudou  = mud_r;
    assign bus.erro   = err_r;
endmodule

// File: doc/decodificador_alarme.md
# decodificador_alarme

Status decoder for the alarm panel's indicator outputs. It watches the `led` and `sirene` lines that the alarm controller drives. It measures the toggle intervals on those lines and recovers the controller state: standby, alert or triggered. It sits on the supervisory side, feeding the status display and logging logic, and must stay consistent with the controller's blink encoding.

## Interface
- `ALERTA_HALF`, 4: led half-period in cycles while in alert.
- `DISPARO_HALF`, 2: led half-period in cycles while triggered.
- `SIRENE_HALF`, 6: sirene half-period in cycles while triggered.
- `TOL`, 0: accepted ± deviation, in cycles, on every measured interval.
- `TIMEOUT`, 16: cycles without a led edge before a steady line is classified.
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `led` in 1: indicator LED line from the alarm controller, synchronous to `clk`.
- `sirene` in 1: siren line from the alarm controller, synchronous to `clk`.
- `estado` out 2: decoded state, as follows.
  - 00 = STANDBY
  - 01 = ALERTA
  - 10 = DISPARO
  - 11 = INDETERMINADO
- `valido` out 1: high whenever `estado` != 11.
- `mudou` out 1: one-cycle pulse on every change of `estado`.
- `erro` out 1: one-cycle pulse on an encoding violation.

## Operation
**Input sampling and edge detection**
- `led` and `sirene` are registered once.
- An edge is a cycle in which the sample differs from the previous sample.

**Interval measurement**
- Interval I = clock cycles between two consecutive edges on the same line.
- Counters saturate at TIMEOUT and never wrap.
- The first edge after reset, or after a timeout classification, starts a measurement but yields no interval.

**Led interval classification**
- |I − DISPARO_HALF| ≤ TOL → candidate DISPARO.
- Otherwise, |I − ALERTA_HALF| ≤ TOL → candidate ALERTA.
- DISPARO wins if the two bands overlap.
- Otherwise → `erro` pulse and the candidate is cleared.

**Confirmation**
- `estado` takes a candidate only after two consecutive intervals give the same candidate.
- A differing candidate restarts the count at one.
- A confirmed state holds while the intervals keep matching it.

**Sirene checks**
- A sirene interval outside SIRENE_HALF ± TOL → `erro` pulse.
- A sirene edge while `estado` is 00 or 01 → `erro` pulse.
- `estado` is unchanged in both cases.

**Timeout (led counter reaches TIMEOUT with no led edge)**
- Sampled led = 1 and sirene = 0 → `estado` = 00.
- Any other level combination → `estado` = 11.
- The candidate is cleared in both cases.

**Simultaneous events**
- A led edge in the same cycle as timeout expiry: the edge wins and the counter restarts.
- A led error and a sirene error in the same cycle give a single `erro` pulse.

**States and transitions**
- 11 → 00: quiet timeout.
- Any state → 01: two ALERTA intervals.
- Any state → 10: two DISPARO intervals.
- Any state → 11: stuck-level timeout.
- 01/10 → 00: quiet timeout.

## Timing
- Reset values: `estado` = 11, `valido` = 0, `mudou` = 0, `erro` = 0, all counters and the candidate cleared.
- Reset mid-operation forces these values immediately and asynchronously.
- A line change before rising edge k is detected at edge k+1.
- `estado`, `mudou` and `erro` are updated at edge k+2; total latency is 2 cycles from line change to output.
- `valido` follows `estado` in the same cycle.
- `mudou` is high for exactly one cycle per change.
- Timeout transitions land 2 cycles after the TIMEOUT-th quiet cycle.
- Outputs are fully registered; there are no combinational paths from inputs.

## Test plan
- **Quiet start:** release reset with led=1, sirene=0 held.
  - `estado` stays 11 and `valido` stays 0 through the timeout.
  - `estado` then goes 00 with one `mudou` pulse; `erro` never asserts.
- **Alert:** from STANDBY, toggle led every 4 cycles.
  - No change after the first interval.
  - `estado` = 01 two cycles after the third edge (second interval), with one `mudou` pulse.
- **Triggered:** toggle led every 2 cycles and sirene every 6 cycles.
  - `estado` = 10 after the second led interval.
  - No `erro`, including on sirene edges.
- **Bad interval:** in ALERTA, insert one 7-cycle led interval.
  - One `erro` pulse; `estado` stays 01.
  - Two further 4-cycle intervals keep it at 01 with no `mudou`.
- **Violations:** in ALERTA, one sirene toggle → one `erro` pulse.
  - Then hold led=0 for 16 cycles → `estado` = 11, `valido` = 0, one `mudou` pulse.
- **Mid-operation reset:** assert reset while in DISPARO mid-interval.
  - Outputs immediately 11/0/0/0.
  - After release, two led edges are required before any classification.
